// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: mode encoding and default timing constants.
// The display driver also imports this package.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } state_t;

  localparam int CLK_HZ_DEF     = 100_000_000;
  localparam int TICK_HZ_DEF    = 100;
  localparam int DEB_CYCLES_DEF = 1_000_000;

  function automatic logic is_running(input state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, and a
// one-cycle press pulse on each accepted rising level.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      level_d <= level;
      press   <= level & ~level_d;
      // Any agreeing sample restarts the stability window.
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: button conditioning, IDLE/RUN/LAP/STOP FSM,
// centisecond prescaler, and the clear/freeze strobes for the datapath.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int TICK_HZ    = TICK_HZ_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  output logic       count_en,
  output logic       clear,
  output logic       freeze,
  output logic       running,
  output logic [1:0] state
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  state_t           state_q;
  state_t           state_d;
  logic [PRE_W-1:0] presc;
  logic             advance;
  logic             ss_press;
  logic             lp_press;
  logic             ss_level_unused;
  logic             lp_level_unused;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ss_deb (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(start_stop),
    .level  (ss_level_unused),
    .press  (ss_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_lp_deb (
    .clk    (clk),
    .reset  (reset),
    .btn_raw(lap),
    .level  (lp_level_unused),
    .press  (lp_press)
  );

  // start_stop is tested first everywhere, so it wins a same-cycle collision.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ss_press) state_d = RUN;
      RUN:  if (ss_press) state_d = STOP; else if (lp_press) state_d = LAP;
      LAP:  if (ss_press) state_d = STOP; else if (lp_press) state_d = RUN;
      STOP: if (ss_press) state_d = RUN;  else if (lp_press) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The prescaler only moves while running now and next, so no tick can land
  // in a cycle that shows STOP/IDLE, and the partial count survives a stop.
  assign advance = is_running(state_q) && is_running(state_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      presc    <= '0;
      count_en <= 1'b0;
      clear    <= 1'b1;
      freeze   <= 1'b0;
      running  <= 1'b0;
    end else begin
      state_q  <= state_d;
      freeze   <= (state_d == LAP);
      running  <= is_running(state_d);
      clear    <= (state_q == STOP) && (state_d == IDLE);
      count_en <= advance && (presc == PRE_MAX);
      if (state_d == IDLE) begin
        presc <= '0;
      end else if (advance) begin
        presc <= (presc == PRE_MAX) ? '0 : presc + 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl (DIV=10, DEB_CYCLES=4) with a tick scoreboard.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       reset;
  logic       start_stop;
  logic       lap;
  logic       count_en;
  logic       clear;
  logic       freeze;
  logic       running;
  logic [1:0] state;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int exp_q[$];

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_LAP  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  stopwatch_ctrl #(
    .CLK_HZ    (1000),
    .TICK_HZ   (100),
    .DEB_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_stop(start_stop),
    .lap       (lap),
    .count_en  (count_en),
    .clear     (clear),
    .freeze    (freeze),
    .running   (running),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  // Advance one cycle and score count_en against the expected tick cycles.
  task automatic step();
    @(negedge clk);
    if (exp_q.size() > 0 && exp_q[0] == cyc) begin
      chk("count_en_tick", {1'b0, count_en}, 2'd1);
      void'(exp_q.pop_front());
    end else begin
      chk("count_en_quiet", {1'b0, count_en}, 2'd0);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic push_ticks(input int first, input int last);
    for (int t = first; t <= last; t += 10) exp_q.push_back(t);
  endtask

  // Raw high first sampled at edge cyc+1; FSM acts at edge cyc+8.
  task automatic press(input logic s, input logic l, output int tr);
    start_stop = s;
    lap = l;
    tr = cyc + 8;
    repeat (8) step();
    start_stop = 1'b0;
    lap = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tr;
    reset = 1'b1;
    start_stop = 1'b0;
    lap = 1'b0;

    // Reset held for 3 edges
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("rst_clear", {1'b0, clear}, 2'd1);
      chk("rst_state", state, S_IDLE);
      chk("rst_freeze", {1'b0, freeze}, 2'd0);
      chk("rst_running", {1'b0, running}, 2'd0);
    end
    reset = 1'b0;
    step();
    chk("post_rst_clear", {1'b0, clear}, 2'd0);
    chk("post_rst_state", state, S_IDLE);

    // Bouncing start_stop, settled high from edge 10
    step(); start_stop = 1'b1;
    step(); start_stop = 1'b0;
    step(); start_stop = 1'b1;
    step(); start_stop = 1'b0;
    step(); start_stop = 1'b1;
    wait_to(16);
    chk("bounce_still_idle", state, S_IDLE);
    step();
    chk("bounce_run", state, S_RUN);
    chk("bounce_running", {1'b0, running}, 2'd1);
    chk("bounce_freeze", {1'b0, freeze}, 2'd0);
    start_stop = 1'b0;
    push_ticks(27, 37);

    // Stop with prescaler at 5, then resume
    wait_to(35);
    press(1'b1, 1'b0, tr);
    chk("stop_state", state, S_STOP);
    chk("stop_running", {1'b0, running}, 2'd0);
    wait_to(55);
    chk("stop_held", state, S_STOP);
    press(1'b1, 1'b0, tr);
    chk("resume_state", state, S_RUN);
    push_ticks(tr + 5, tr + 15);

    // Lap enter and exit
    wait_to(70);
    press(1'b0, 1'b1, tr);
    chk("lap_state", state, S_LAP);
    chk("lap_freeze", {1'b0, freeze}, 2'd1);
    chk("lap_running", {1'b0, running}, 2'd1);
    push_ticks(88, 98);
    wait_to(90);
    press(1'b0, 1'b1, tr);
    chk("unlap_state", state, S_RUN);
    chk("unlap_freeze", {1'b0, freeze}, 2'd0);
    push_ticks(108, 108);

    // Simultaneous presses: start_stop wins
    wait_to(105);
    press(1'b1, 1'b1, tr);
    chk("both_state", state, S_STOP);
    chk("both_freeze", {1'b0, freeze}, 2'd0);

    // lap in STOP clears back to IDLE
    wait_to(125);
    press(1'b0, 1'b1, tr);
    chk("clr_state", state, S_IDLE);
    chk("clr_pulse", {1'b0, clear}, 2'd1);
    step();
    chk("clr_pulse_end", {1'b0, clear}, 2'd0);

    // Fresh run: first tick exactly 10 cycles after RUN shows
    wait_to(140);
    press(1'b1, 1'b0, tr);
    chk("rerun_state", state, S_RUN);
    push_ticks(tr + 10, tr + 10);
    wait_to(150);
    press(1'b0, 1'b1, tr);
    chk("lap2_state", state, S_LAP);
    chk("lap2_freeze", {1'b0, freeze}, 2'd1);

    // Reset in LAP before the tick due at 168
    wait_to(164);
    reset = 1'b1;
    step();
    chk("midrst_state", state, S_IDLE);
    chk("midrst_freeze", {1'b0, freeze}, 2'd0);
    chk("midrst_running", {1'b0, running}, 2'd0);
    chk("midrst_clear", {1'b0, clear}, 2'd1);
    wait_to(168);
    reset = 1'b0;
    step();
    chk("midrst_clear_end", {1'b0, clear}, 2'd0);
    chk("midrst_idle", state, S_IDLE);
    wait_to(185);
    chk("ticks_pending", {1'b0, exp_q.size() == 0}, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
